// File: rtl/simplebus_rr_arbiter.sv
// Round-robin arbiter sharing one Simplebus slave port among N_MASTERS masters.
// Define SB_ARB_TIMEOUT_EN to add the per-transaction watchdog abort and sticky timeout_err.
module simplebus_rr_arbiter #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_MASTERS*32-1:0]      m_address,
    input  logic [N_MASTERS-1:0]         m_write_strobe,
    input  logic [N_MASTERS*32-1:0]      m_write_data,
    input  logic [N_MASTERS-1:0]         m_read_strobe,
    output logic [N_MASTERS*32-1:0]      m_read_data,
    output logic [N_MASTERS-1:0]         m_read_valid,
    output logic [N_MASTERS-1:0]         m_ready,
    output logic [31:0]                  s_address,
    output logic                         s_write_strobe,
    output logic [31:0]                  s_write_data,
    output logic                         s_read_strobe,
    input  logic [31:0]                  s_read_data,
    input  logic                         s_read_valid,
    input  logic                         s_ready,
    output logic [$clog2(N_MASTERS)-1:0] grant,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {IDLE, WR_ACK, WR_DONE, RD_WAIT} state_t;
    state_t state_q, state_d;

    logic [N_MASTERS-1:0] pend_q, pend_d, is_wr_q, is_wr_d;
    logic [N_MASTERS-1:0] ready_q, ready_d, rvalid_q, rvalid_d;
    logic [31:0]          addr_q  [N_MASTERS];
    logic [31:0]          addr_d  [N_MASTERS];
    logic [31:0]          wdata_q [N_MASTERS];
    logic [31:0]          wdata_d [N_MASTERS];
    logic [31:0]          rdata_q [N_MASTERS];
    logic [31:0]          rdata_d [N_MASTERS];
    logic [IDX_W-1:0]     ptr_q, ptr_d, grant_q, grant_d, sel_idx, cand_idx;
    logic [31:0]          s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic                 s_wstb_q, s_wstb_d, s_rstb_q, s_rstb_d, busy_q, busy_d;
    logic                 found, issue, wr_done, rd_done, abort, finish;
    int unsigned          cand;

    // First pending slot strictly after the pointer, wrapping modulo N_MASTERS.
    always_comb begin
        sel_idx  = ptr_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N_MASTERS) cand = cand - N_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!found && pend_q[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    assign issue   = (state_q == IDLE) && s_ready && found;
    assign wr_done = (state_q == WR_DONE) && s_ready;
    assign rd_done = (state_q == RD_WAIT) && s_read_valid;
    assign finish  = wr_done || rd_done || abort;

`ifdef SB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    assign abort = (state_q != IDLE) && !wr_done && !rd_done
                   && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q || abort;
        if (issue)                 tmo_cnt_d = '0;
        else if (state_q != IDLE)  tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue)        state_d = is_wr_q[sel_idx] ? WR_ACK : RD_WAIT;
            WR_ACK:  if (!s_ready)     state_d = WR_DONE;
            WR_DONE: if (s_ready)      state_d = IDLE;
            RD_WAIT: if (s_read_valid) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        pend_d    = pend_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = '0;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstb_d  = 1'b0;
        s_rstb_d  = 1'b0;

        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (ready_q[i] && (m_write_strobe[i] || m_read_strobe[i])) begin
                pend_d[i]  = 1'b1;
                is_wr_d[i] = m_write_strobe[i];
                addr_d[i]  = m_address[32*i +: 32];
                wdata_d[i] = m_write_data[32*i +: 32];
            end
        end

        if (issue) begin
            ptr_d     = sel_idx;
            grant_d   = sel_idx;
            busy_d    = 1'b1;
            s_addr_d  = addr_q[sel_idx];
            s_wdata_d = wdata_q[sel_idx];
            s_wstb_d  = is_wr_q[sel_idx];
            s_rstb_d  = !is_wr_q[sel_idx];
        end

        if (finish) begin
            pend_d[grant_q] = 1'b0;
            busy_d          = 1'b0;
        end
        if (rd_done) begin
            rdata_d[grant_q]  = s_read_data;
            rvalid_d[grant_q] = 1'b1;
        end else if (abort && (state_q == RD_WAIT)) begin
            rdata_d[grant_q]  = 32'hDEADBEEF;
            rvalid_d[grant_q] = 1'b1;
        end

        ready_d = ~pend_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q    <= '0;
            is_wr_q   <= '0;
            ready_q   <= '0;
            rvalid_q  <= '0;
            addr_q    <= '{default: '0};
            wdata_q   <= '{default: '0};
            rdata_q   <= '{default: '0};
            ptr_q     <= IDX_W'(N_MASTERS - 1);
            grant_q   <= '0;
            busy_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstb_q  <= 1'b0;
            s_rstb_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            is_wr_q   <= is_wr_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstb_q  <= s_wstb_d;
            s_rstb_q  <= s_rstb_d;
        end
    end

    always_comb begin
        m_read_data = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) m_read_data[32*i +: 32] = rdata_q[i];
    end

    assign m_read_valid   = rvalid_q;
    assign m_ready        = ready_q;
    assign s_address      = s_addr_q;
    assign s_write_data   = s_wdata_q;
    assign s_write_strobe = s_wstb_q;
    assign s_read_strobe  = s_rstb_q;
    assign grant          = grant_q;
    assign busy           = busy_q;
endmodule
